mem_stage_hs: RTL
=================

Name: mem_stage_hs

Overview:
Next-generation memory-access pipeline stage for the 5-stage core. It sits between EX and WB, registers the EX result, and issues its own data-memory request over a req/gnt/rvalid handshake, so memory may take a variable number of cycles. It aligns and sign- or zero-extends sub-word loads by address offset, generates store byte enables, and flags misaligned accesses. It stalls the pipeline while an access is outstanding and exports a forwarding bus to ID that includes a load-pending flag.

Parameters:
PC_W, 32, width of PC carried to WB
ADDR_W, 32, data address width; bits [1:0] select the byte lane
REG_AW, 5, register-file address width
MAX_WAIT, 15, cycles in REQ or WAIT_DATA before the access is aborted with timeout_err

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_in  in  1  downstream/hazard hold; stage register keeps its contents
flush  in  1  on an accept cycle, capture a bubble instead of EX data
ex_valid  in  1  EX slot holds a real instruction
ex_pc  in  PC_W  instruction PC
ex_result  in  32  ALU result or effective address
ex_mem_en  in  1  memory operation
ex_mem_we  in  1  1=store, 0=load
ex_size  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW (stores use the SB/SH/SW meaning of 000/010/100)
ex_store_data  in  32  rt value for stores
ex_rf_we  in  1  writes register file
ex_rf_waddr  in  REG_AW  destination register
dmem_req  out  1  request valid
dmem_we  out  1  write request
dmem_be  out  4  byte enables
dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
dmem_wdata  out  32  store data replicated to its lanes
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid; earliest one cycle after gnt
dmem_rdata  in  32  read word
wb_valid  out  1  completed instruction presented to WB this cycle
wb_pc  out  PC_W  PC of the completing instruction
wb_rf_we  out  1  register-file write enable
wb_rf_waddr  out  REG_AW  register-file write address
wb_rf_wdata  out  32  register-file write data
fwd_we, fwd_waddr, fwd_wdata  out  1/REG_AW/32  forwarding to ID; equal to wb_* in the completion cycle
fwd_pending  out  1  the stage holds a load whose data is not yet available
stallreq  out  1  stage busy; upstream must hold
misalign  out  1  one-cycle pulse when an access is misaligned
timeout_err  out  1  one-cycle pulse when an access is aborted

Behaviour:
- Stage register (valid bit plus all ex_* fields) loads in an accept cycle: accept = done_or_empty & ~stall_in.
  - If flush is set in an accept cycle, a bubble (valid=0) is loaded.
  - If stall_in is set, the register holds.
  - flush is sampled only in accept cycles.
- FSM states: IDLE, REQ, WAIT_DATA.
  - IDLE, register empty or a non-memory op: done in the same cycle.
  - IDLE with a valid, aligned memory op: dmem_req=1 combinationally.
    - gnt=1 and store: done this cycle.
    - gnt=1 and load: go to WAIT_DATA.
    - gnt=0: go to REQ.
  - REQ: hold req, address, data and be stable until gnt, then continue as in IDLE.
  - WAIT_DATA: done in the cycle rvalid=1; return to IDLE.
  - An rvalid seen outside WAIT_DATA is ignored.
- Misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0):
  - no request is issued; misalign pulses.
  - The op completes in 1 cycle with wb_rf_we=0.
- Load data is extracted from lane addr[1:0] (halfword lane addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes the word through.
  - Non-load writeback data is ex_result.
- Store byte enables:
  - SB: be = 1<<addr[1:0], wdata = {4{b}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{h}}.
  - SW: be = 1111.
- Timeout: a wait counter resets on entry to REQ; it increments in REQ and WAIT_DATA. On reaching MAX_WAIT:
  - timeout_err pulses and the FSM returns to IDLE;
  - dmem_req drops;
  - the op completes with wb_rf_we=0.
- Outputs:
  - wb_valid = done & register valid.
  - wb_rf_we = wb_valid & rf_we & ~misalign & ~timeout.
  - stallreq = register valid & ~done.
  - fwd_pending = register valid & load & ~done.
- Reset values: register cleared; FSM IDLE; counter 0; every output 0. Reset mid-access drops dmem_req in the following cycle, and no writeback occurs.

Test Plan:
- ALU op ex_result=0x1234_5678, rf_waddr=3, no stall -> one cycle later wb_valid=1, wb_rf_wdata=0x12345678, stallreq=0.
- LB addr=0x103 with gnt in the same cycle, rvalid 2 cycles later with rdata=0x80AB_CD12 -> wdata=0xFFFF_FF80; stallreq high for 2 cycles; fwd_pending high until rvalid.
- LHU addr=0x102 with rdata=0x8001_0000 -> 0x0000_8001. SB addr=0x101 data=0xA5 -> be=0010, wdata=0xA5A5_A5A5, completes on gnt.
- LW addr=0x102 -> misalign pulse, no dmem_req, wb_rf_we=0, stage free next cycle.
- gnt held low 3 cycles -> req, addr and be stable throughout. Separately, rvalid never arrives -> timeout_err pulses after 15 cycles with no RF write.
- rst asserted in WAIT_DATA -> next cycle all outputs 0, FSM IDLE. A flush in an accept cycle -> bubble, wb_valid=0.

Source files
------------

// File: rtl/mem_stage_hs.sv
// Memory-access stage between EX and WB: registers the EX slot and runs a
// req/gnt/rvalid data-memory access with lane alignment and a wait timeout.
module mem_stage_hs #(
   parameter int PC_W     = 32,
   parameter int ADDR_W   = 32,
   parameter int REG_AW   = 5,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic [31:0]       ex_result,
   input  logic              ex_mem_en,
   input  logic              ex_mem_we,
   input  logic [2:0]        ex_size,
   input  logic [31:0]       ex_store_data,
   input  logic              ex_rf_we,
   input  logic [REG_AW-1:0] ex_rf_waddr,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [3:0]        dmem_be,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic              wb_valid,
   output logic [PC_W-1:0]   wb_pc,
   output logic              wb_rf_we,
   output logic [REG_AW-1:0] wb_rf_waddr,
   output logic [31:0]       wb_rf_wdata,
   output logic              fwd_we,
   output logic [REG_AW-1:0] fwd_waddr,
   output logic [31:0]       fwd_wdata,
   output logic              fwd_pending,
   output logic              stallreq,
   output logic              misalign,
   output logic              timeout_err
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
   logic              v_q, v_d, mem_en_q, mem_en_d, we_q, we_d;
   logic              rf_we_q, rf_we_d, held_q, held_d, wbwe_q, wbwe_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       res_q, res_d, sd_q, sd_d, wbd_q, wbd_d;
   logic [2:0]        size_q, size_d;
   logic [REG_AW-1:0] waddr_q, waddr_d;

   logic [ADDR_W-1:0] addr;
   logic              is_mem, is_load, misal, tmo_hit;
   logic              req, done, tmo, mis, accept, live_we;
   logic [31:0]       rsh, ld_data, live_data, st_data;
   logic [3:0]        st_be;

   assign addr    = res_q[ADDR_W-1:0];
   assign cnt_inc = cnt_q + CW'(1);
   assign tmo_hit = (cnt_inc == CW'(MAX_WAIT));

   always_comb begin
      is_mem  = v_q & mem_en_q;
      is_load = mem_en_q & ~we_q;
      misal   = size_q[2] ? (addr[1:0] != 2'b00)
                          : (size_q[1] & addr[0]);
      // shifting by the lane puts the addressed byte/half at bit 0
      rsh = dmem_rdata >> {addr[1:0], 3'b000};
      case (size_q)
         3'b000:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
         3'b001:  ld_data = {24'b0, rsh[7:0]};
         3'b010:  ld_data = {{16{rsh[15]}}, rsh[15:0]};
         3'b011:  ld_data = {16'b0, rsh[15:0]};
         default: ld_data = dmem_rdata;
      endcase
      case (size_q[2:1])
         2'b00: begin
            st_be   = 4'b0001 << addr[1:0];
            st_data = {4{sd_q[7:0]}};
         end
         2'b01: begin
            st_be   = addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{sd_q[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = sd_q;
         end
      endcase
      live_data = is_load ? ld_data : res_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req     = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      mis     = 1'b0;
      case (state_q)
         IDLE: begin
            if (held_q || !is_mem) begin
               done = 1'b1;
            end else if (misal) begin
               done = 1'b1;
               mis  = 1'b1;
            end else begin
               req   = 1'b1;
               cnt_d = '0;
               if (!dmem_gnt)  state_d = REQ;
               else if (we_q)  done    = 1'b1;
               else            state_d = WAIT_DATA;
            end
         end
         REQ: begin
            cnt_d = cnt_inc;
            if (tmo_hit) begin
               done    = 1'b1;
               tmo     = 1'b1;
               state_d = IDLE;
            end else begin
               req = 1'b1;
               if (dmem_gnt) begin
                  if (we_q) begin
                     done    = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = WAIT_DATA;
                  end
               end
            end
         end
         WAIT_DATA: begin
            cnt_d = cnt_inc;
            if (dmem_rvalid) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (tmo_hit) begin
               done    = 1'b1;
               tmo     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept   = done & ~stall_in;
      v_d      = v_q;
      pc_d     = pc_q;
      res_d    = res_q;
      mem_en_d = mem_en_q;
      we_d     = we_q;
      size_d   = size_q;
      sd_d     = sd_q;
      rf_we_d  = rf_we_q;
      waddr_d  = waddr_q;
      if (accept) begin
         v_d      = ex_valid & ~flush;
         pc_d     = ex_pc;
         res_d    = ex_result;
         mem_en_d = ex_mem_en;
         we_d     = ex_mem_we;
         size_d   = ex_size;
         sd_d     = ex_store_data;
         rf_we_d  = ex_rf_we;
         waddr_d  = ex_rf_waddr;
      end
      live_we = rf_we_q & ~mis & ~tmo;
      // a completed op held by stall_in must not re-issue its access
      held_d  = v_q & done & stall_in;
      wbd_d   = held_q ? wbd_q : live_data;
      wbwe_d  = held_q ? wbwe_q : live_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         v_q      <= 1'b0;
         pc_q     <= '0;
         res_q    <= '0;
         mem_en_q <= 1'b0;
         we_q     <= 1'b0;
         size_q   <= '0;
         sd_q     <= '0;
         rf_we_q  <= 1'b0;
         waddr_q  <= '0;
         held_q   <= 1'b0;
         wbd_q    <= '0;
         wbwe_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         v_q      <= v_d;
         pc_q     <= pc_d;
         res_q    <= res_d;
         mem_en_q <= mem_en_d;
         we_q     <= we_d;
         size_q   <= size_d;
         sd_q     <= sd_d;
         rf_we_q  <= rf_we_d;
         waddr_q  <= waddr_d;
         held_q   <= held_d;
         wbd_q    <= wbd_d;
         wbwe_q   <= wbwe_d;
      end
   end

   assign dmem_req    = req;
   assign dmem_we     = req & we_q;
   assign dmem_be     = req ? st_be : 4'b0000;
   assign dmem_addr   = req ? {addr[ADDR_W-1:2], 2'b00} : '0;
   assign dmem_wdata  = (req & we_q) ? st_data : '0;
   assign wb_valid    = done & v_q;
   assign wb_pc       = wb_valid ? pc_q : '0;
   assign wb_rf_waddr = wb_valid ? waddr_q : '0;
   assign wb_rf_wdata = !wb_valid ? '0 : (held_q ? wbd_q : live_data);
   assign wb_rf_we    = wb_valid & (held_q ? wbwe_q : live_we);
   assign fwd_we      = wb_rf_we;
   assign fwd_waddr   = v_q ? waddr_q : '0;
   assign fwd_wdata   = wb_rf_wdata;
   assign fwd_pending = v_q & is_load & ~done;
   assign stallreq    = v_q & ~done;
   assign misalign    = mis;
   assign timeout_err = tmo;

endmodule
